// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
//   Shares one dcache request port between the load unit (CPU) and the
//   prefetcher (PF). Index phase: one requester is selected and forwarded
//   combinationally. The selection is locked until the cache grants it.
//   Tag phase: in the cycle after a grant, the tag, tag_valid and kill_req
//   come from the granted requester. Responses are routed back in order
//   through a small owner FIFO. At most MAX_OUTSTANDING granted requests
//   can wait for rvalid at once.
//
//   Ports:
//     clk_i, rst_ni  clock and synchronous active-low reset
//     cpu_port_i/o   load-unit request / response
//     pf_port_i/o    prefetcher request / response
//     cache_port_o   request towards the dcache
//     cache_port_i   response from the dcache
//     pf_enable_i    0 = no new prefetch request is selected
//
//   Optional feature: define PF_ARB_STARVE_PROTECT_EN to add a starvation
//   counter. A prefetch request blocked for PF_STARVE_LIMIT cycles then gets
//   priority. Without the macro, the CPU has strict priority.

package dcache_port_arbiter_pkg;
  localparam int unsigned IDX_W  = 12;
  localparam int unsigned TAG_W  = 20;
  localparam int unsigned DATA_W = 64;

  typedef struct packed {
    logic [IDX_W-1:0]    address_index;
    logic [TAG_W-1:0]    address_tag;
    logic [DATA_W-1:0]   data_wdata;
    logic                data_req;
    logic                data_we;
    logic [DATA_W/8-1:0] data_be;
    logic [1:0]          data_size;
    logic                kill_req;
    logic                tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic              data_gnt;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic {OWN_CPU = 1'b0, OWN_PF = 1'b1} owner_e;
endpackage

module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned PF_STARVE_LIMIT = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  dcache_req_i_t cpu_port_i,
  output dcache_req_o_t cpu_port_o,
  input  dcache_req_i_t pf_port_i,
  output dcache_req_o_t pf_port_o,
  output dcache_req_i_t cache_port_o,
  input  dcache_req_o_t cache_port_i,
  input  logic          pf_enable_i
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] FIFO_DEPTH = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(MAX_OUTSTANDING - 1);

  owner_e           fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q;
  logic             lock_valid_q;
  owner_e           lock_owner_q;
  logic             tag_phase_q;
  owner_e           tag_owner_q;

  logic          pf_eligible, starve_prio;
  logic          sel_valid, sel_req, fwd_req, gnt_fire;
  owner_e        sel_owner, head_owner;
  logic          fifo_full, fifo_empty, pop, stray_rvalid;
  dcache_req_i_t sel_src, tag_src;

  assign pf_eligible  = pf_port_i.data_req && pf_enable_i;
  assign fifo_full    = (fifo_cnt_q == FIFO_DEPTH);
  assign fifo_empty   = (fifo_cnt_q == '0);
  assign head_owner   = fifo_q[rd_ptr_q];
  assign pop          = cache_port_i.data_rvalid && !fifo_empty;
  assign stray_rvalid = cache_port_i.data_rvalid && fifo_empty;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sel_valid = 1'b0;
    sel_owner = OWN_CPU;
    if (lock_valid_q) begin
      // A PF handshake that is already locked finishes even if pf_enable_i has dropped.
      sel_valid = 1'b1;
      sel_owner = lock_owner_q;
    end else if (starve_prio && pf_eligible) begin
      sel_valid = 1'b1;
      sel_owner = OWN_PF;
    end else if (cpu_port_i.data_req) begin
      sel_valid = 1'b1;
      sel_owner = OWN_CPU;
    end else if (pf_eligible) begin
      sel_valid = 1'b1;
      sel_owner = OWN_PF;
    end
  end

  assign sel_src  = (sel_owner == OWN_PF) ? pf_port_i : cpu_port_i;
  assign tag_src  = (tag_owner_q == OWN_PF) ? pf_port_i : cpu_port_i;
  assign sel_req  = sel_valid && sel_src.data_req;
  // A full FIFO blocks the request even when this cycle's rvalid frees an entry.
  assign fwd_req  = sel_req && !fifo_full;
  assign gnt_fire = fwd_req && cache_port_i.data_gnt;

  always_comb begin
    cache_port_o = '0;
    if (sel_valid) begin
      cache_port_o.address_index = sel_src.address_index;
      cache_port_o.data_wdata    = sel_src.data_wdata;
      cache_port_o.data_we       = sel_src.data_we;
      cache_port_o.data_be       = sel_src.data_be;
      cache_port_o.data_size     = sel_src.data_size;
    end
    cache_port_o.data_req = fwd_req;
    if (tag_phase_q) begin
      cache_port_o.address_tag = tag_src.address_tag;
      cache_port_o.tag_valid   = tag_src.tag_valid;
      cache_port_o.kill_req    = tag_src.kill_req;
    end
  end

  always_comb begin
    cpu_port_o             = '0;
    pf_port_o              = '0;
    cpu_port_o.data_rdata  = cache_port_i.data_rdata;
    pf_port_o.data_rdata   = cache_port_i.data_rdata;
    cpu_port_o.data_gnt    = gnt_fire && (sel_owner == OWN_CPU);
    pf_port_o.data_gnt     = gnt_fire && (sel_owner == OWN_PF);
    cpu_port_o.data_rvalid = pop && (head_owner == OWN_CPU);
    pf_port_o.data_rvalid  = pop && (head_owner == OWN_PF);
  end

  // NOTE: FIFO storage has no reset. Clearing the count and pointers already makes it empty.
  always_ff @(posedge clk_i) begin
    if (gnt_fire) fifo_q[wr_ptr_q] <= sel_owner;
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= OWN_CPU;
      tag_phase_q  <= 1'b0;
      tag_owner_q  <= OWN_CPU;
    end else begin
      if (gnt_fire) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({gnt_fire, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      if (gnt_fire) begin
        lock_valid_q <= 1'b0;
      end else if (fwd_req) begin
        lock_valid_q <= 1'b1;
        lock_owner_q <= sel_owner;
      end
      tag_phase_q <= gnt_fire;
      tag_owner_q <= sel_owner;
    end
  end

`ifdef PF_ARB_STARVE_PROTECT_EN
  logic [7:0] starve_cnt_q;

  assign starve_prio = (starve_cnt_q >= 8'(PF_STARVE_LIMIT));

  // The counter saturates at the limit. It holds while the prefetcher is disabled.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
    end else if (!pf_port_i.data_req || pf_port_o.data_gnt) begin
      starve_cnt_q <= '0;
    end else if (pf_enable_i && !starve_prio) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end
`else
  logic [7:0] unused_starve_limit;

  assign starve_prio         = 1'b0;
  assign unused_starve_limit = 8'(PF_STARVE_LIMIT);
`endif

  // An rvalid with nothing outstanding is dropped. It is not routed and does not pop.
  always_ff @(posedge clk_i) begin
    if (rst_ni && cache_port_i.data_rvalid) begin
      assert (!stray_rvalid)
        else $warning("dcache_port_arbiter: rvalid received with no outstanding request");
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed testbench for dcache_port_arbiter (MAX_OUTSTANDING=2, PF_STARVE_LIMIT=4).
// Inputs change 1 ns after the rising edge. Outputs are sampled on the falling edge.
// The file is self-checking.
module tb_dcache_port_arbiter;
  import dcache_port_arbiter_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          pf_enable_i;
  dcache_req_i_t cpu_in, pf_in, cache_req;
  dcache_req_o_t cpu_rsp, pf_rsp, cache_rsp;

  int errors = 0;
  int checks = 0;
  int pf_grants;
  int first_pf;
  int cpu_after;

  always #5 clk_i = ~clk_i;

  dcache_port_arbiter #(
    .MAX_OUTSTANDING(2),
    .PF_STARVE_LIMIT(4)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cpu_port_i  (cpu_in),
    .cpu_port_o  (cpu_rsp),
    .pf_port_i   (pf_in),
    .pf_port_o   (pf_rsp),
    .cache_port_o(cache_req),
    .cache_port_i(cache_rsp),
    .pf_enable_i (pf_enable_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni      = 1'b0;
    pf_enable_i = 1'b1;
    cpu_in      = '0;
    pf_in       = '0;
    cache_rsp   = '0;
    tick();
    tick();

    // Reset state
    sample();
    check("rst_cache_zero", 64'(cache_req === '0), 64'd1);
    check("rst_cpu_gnt", 64'(cpu_rsp.data_gnt), 64'd0);
    check("rst_pf_rvalid", 64'(pf_rsp.data_rvalid), 64'd0);
    tick();
    rst_ni = 1'b1;

    // CPU load alone, same-cycle grant, tag next cycle, rvalid two cycles later
    cpu_in.data_req      = 1'b1;
    cpu_in.address_index = 12'h123;
    cpu_in.data_be       = 8'hFF;
    cpu_in.data_size     = 2'd3;
    cache_rsp.data_gnt   = 1'b1;
    sample();
    check("cpu_fwd_req", 64'(cache_req.data_req), 64'd1);
    check("cpu_fwd_index", 64'(cache_req.address_index), 64'h123);
    check("cpu_gnt", 64'(cpu_rsp.data_gnt), 64'd1);
    check("cpu_pf_no_gnt", 64'(pf_rsp.data_gnt), 64'd0);
    tick();
    cpu_in.data_req     = 1'b0;
    cpu_in.address_tag  = 20'hABCDE;
    cpu_in.tag_valid    = 1'b1;
    cache_rsp.data_gnt  = 1'b0;
    sample();
    check("cpu_tag_valid", 64'(cache_req.tag_valid), 64'd1);
    check("cpu_tag", 64'(cache_req.address_tag), 64'hABCDE);
    check("cpu_idle_req", 64'(cache_req.data_req), 64'd0);
    tick();
    cpu_in.tag_valid = 1'b0;
    sample();
    check("cpu_tag_done", 64'(cache_req.tag_valid), 64'd0);
    tick();
    cache_rsp.data_rvalid = 1'b1;
    cache_rsp.data_rdata  = 64'hDEADBEEF_00000001;
    sample();
    check("cpu_rvalid", 64'(cpu_rsp.data_rvalid), 64'd1);
    check("cpu_rvalid_pf", 64'(pf_rsp.data_rvalid), 64'd0);
    check("cpu_rdata", cpu_rsp.data_rdata, 64'hDEADBEEF_00000001);
    check("pf_rdata_pass", pf_rsp.data_rdata, 64'hDEADBEEF_00000001);
    tick();
    cache_rsp.data_rvalid = 1'b0;

    // Outstanding limit: two grants, third request blocked until one rvalid
    cpu_in.data_req      = 1'b1;
    cpu_in.address_index = 12'h001;
    cache_rsp.data_gnt   = 1'b1;
    sample();
    check("full_gnt1", 64'(cpu_rsp.data_gnt), 64'd1);
    tick();
    cpu_in.address_index = 12'h002;
    sample();
    check("full_gnt2", 64'(cpu_rsp.data_gnt), 64'd1);
    tick();
    cpu_in.address_index = 12'h003;
    sample();
    check("full_req_held", 64'(cache_req.data_req), 64'd0);
    check("full_no_gnt", 64'(cpu_rsp.data_gnt), 64'd0);
    tick();
    cache_rsp.data_rvalid = 1'b1;
    cache_rsp.data_rdata  = 64'h11;
    sample();
    check("full_pop_req_held", 64'(cache_req.data_req), 64'd0);
    check("full_pop_rvalid", 64'(cpu_rsp.data_rvalid), 64'd1);
    tick();
    cache_rsp.data_rvalid = 1'b0;
    sample();
    check("full_resume_req", 64'(cache_req.data_req), 64'd1);
    check("full_resume_index", 64'(cache_req.address_index), 64'h003);
    check("full_resume_gnt", 64'(cpu_rsp.data_gnt), 64'd1);
    tick();
    cpu_in.data_req       = 1'b0;
    cache_rsp.data_gnt    = 1'b0;
    cache_rsp.data_rvalid = 1'b1;
    sample();
    check("drain1_rvalid", 64'(cpu_rsp.data_rvalid), 64'd1);
    tick();
    sample();
    check("drain2_rvalid", 64'(cpu_rsp.data_rvalid), 64'd1);
    tick();
    cache_rsp.data_rvalid = 1'b0;

    // Selection lock on PF, then PF and CPU grants with in-order responses
    pf_in.data_req      = 1'b1;
    pf_in.address_index = 12'h0AA;
    sample();
    check("lock_pf_index", 64'(cache_req.address_index), 64'h0AA);
    check("lock_pf_no_gnt", 64'(pf_rsp.data_gnt), 64'd0);
    tick();
    cpu_in.data_req      = 1'b1;
    cpu_in.address_index = 12'h0CC;
    sample();
    check("lock_held_index", 64'(cache_req.address_index), 64'h0AA);
    check("lock_cpu_no_gnt", 64'(cpu_rsp.data_gnt), 64'd0);
    tick();
    cache_rsp.data_gnt = 1'b1;
    sample();
    check("lock_pf_gnt", 64'(pf_rsp.data_gnt), 64'd1);
    check("lock_cpu_gnt0", 64'(cpu_rsp.data_gnt), 64'd0);
    tick();
    pf_in.data_req     = 1'b0;
    pf_in.address_tag  = 20'h11111;
    pf_in.tag_valid    = 1'b1;
    pf_in.kill_req     = 1'b1;
    sample();
    check("pf_tag", 64'(cache_req.address_tag), 64'h11111);
    check("pf_kill", 64'(cache_req.kill_req), 64'd1);
    check("cpu_gnt_after_pf", 64'(cpu_rsp.data_gnt), 64'd1);
    tick();
    cpu_in.data_req       = 1'b0;
    cache_rsp.data_gnt    = 1'b0;
    pf_in.tag_valid       = 1'b0;
    pf_in.kill_req        = 1'b0;
    cpu_in.address_tag    = 20'h22222;
    cpu_in.tag_valid      = 1'b1;
    cache_rsp.data_rvalid = 1'b1;
    cache_rsp.data_rdata  = 64'h21;
    sample();
    check("cpu_tag_after_pf", 64'(cache_req.address_tag), 64'h22222);
    check("order_pf_rvalid", 64'(pf_rsp.data_rvalid), 64'd1);
    check("order_pf_cpu0", 64'(cpu_rsp.data_rvalid), 64'd0);
    tick();
    cpu_in.tag_valid = 1'b0;
    sample();
    check("order_cpu_rvalid", 64'(cpu_rsp.data_rvalid), 64'd1);
    check("order_cpu_pf0", 64'(pf_rsp.data_rvalid), 64'd0);
    tick();
    cache_rsp.data_rvalid = 1'b0;

    // Prefetcher disabled: no new PF selection
    pf_enable_i    = 1'b0;
    pf_in.data_req = 1'b1;
    sample();
    check("pf_disabled_req", 64'(cache_req.data_req), 64'd0);
    tick();
    pf_in.data_req = 1'b0;
    pf_enable_i    = 1'b1;
    tick();

    // CPU and PF request every cycle
    pf_grants = 0;
    first_pf  = -1;
    cpu_after = 0;
    cpu_in.data_req    = 1'b1;
    pf_in.data_req     = 1'b1;
    cache_rsp.data_gnt = 1'b1;
`ifdef PF_ARB_STARVE_PROTECT_EN
    for (int i = 0; i < 10; i++) begin
`else
    for (int i = 0; i < 100; i++) begin
`endif
      cache_rsp.data_rvalid = (i > 0);
      sample();
      if (pf_rsp.data_gnt) begin
        pf_grants++;
        if (first_pf < 0) first_pf = i;
      end
      if (i == 5 && cpu_rsp.data_gnt) cpu_after = 1;
      tick();
    end
`ifdef PF_ARB_STARVE_PROTECT_EN
    check("starve_first_pf", 64'(first_pf), 64'd4);
    check("starve_cpu_resume", 64'(cpu_after), 64'd1);
`else
    check("strict_pf_grants", 64'(pf_grants), 64'd0);
`endif
    cpu_in.data_req       = 1'b0;
    pf_in.data_req        = 1'b0;
    cache_rsp.data_gnt    = 1'b0;
    cache_rsp.data_rvalid = 1'b1;
    tick();
    cache_rsp.data_rvalid = 1'b0;

    // Reset with two outstanding, then stray rvalid
    cpu_in.data_req    = 1'b1;
    cache_rsp.data_gnt = 1'b1;
    tick();
    tick();
    cpu_in.data_req    = 1'b0;
    cache_rsp.data_gnt = 1'b0;
    rst_ni             = 1'b0;
    sample();
    check("midrst_fifo_before", 64'(dut.fifo_cnt_q), 64'd2);
    tick();
    rst_ni = 1'b1;
    sample();
    check("midrst_cache_zero", 64'(cache_req === '0), 64'd1);
    check("midrst_fifo_empty", 64'(dut.fifo_cnt_q), 64'd0);
    tick();
    cache_rsp.data_rvalid = 1'b1;
    sample();
    check("stray_flag", 64'(dut.stray_rvalid), 64'd1);
    check("stray_cpu_rvalid", 64'(cpu_rsp.data_rvalid), 64'd0);
    check("stray_pf_rvalid", 64'(pf_rsp.data_rvalid), 64'd0);
    tick();
    cache_rsp.data_rvalid = 1'b0;
    sample();
    check("stray_fifo_empty", 64'(dut.fifo_cnt_q), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, giving the owner-FIFO depth (1..4) and the limit on granted requests awaiting rvalid.
REQ-002 SHALL have parameter PF_STARVE_LIMIT, default 16, giving the consecutive cycles a blocked prefetch request waits before forced service (1..255).
REQ-003 SHALL have ports:
- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  reset; synchronous, active-low
- cpu_port_i  in  dcache_req_i_t  load-unit request
- cpu_port_o  out  dcache_req_o_t  load-unit response
- pf_port_i  in  dcache_req_i_t  prefetcher request
- pf_port_o  out  dcache_req_o_t  prefetcher response
- cache_port_o  out  dcache_req_i_t  request to dcache
- cache_port_i  in  dcache_req_o_t  response from dcache
- pf_enable_i  in  1  0 = prefetcher never selected

Function
REQ-004 SHALL be index phase: select one requester, forward its address_index, data_req, data_we, data_be, data_size and data_wdata to cache_port_o combinationally.
REQ-005 SHALL, with no pending selection lock, select CPU when cpu data_req=1, else PF when pf data_req=1 and pf_enable_i=1.
REQ-006 SHALL hold the selection (lock register) from the first cycle a selected data_req is forwarded ungranted until cache data_gnt=1; no switching mid-handshake.
REQ-007 SHALL return data_gnt only to the selected requester; the other sees data_gnt=0.
REQ-008 SHALL force cache data_req=0 while the owner FIFO holds MAX_OUTSTANDING entries, even if rvalid pops an entry that same cycle.
REQ-009 SHALL, on cache data_gnt=1, push owner (CPU/PF) into the FIFO and store it in tag_owner_q for exactly the next cycle.
REQ-010 SHALL be tag phase: in the cycle after a grant, drive address_tag, tag_valid and kill_req from the requester in tag_owner_q; otherwise tag_valid=0, kill_req=0.
REQ-011 SHALL, on cache data_rvalid=1, pop the FIFO head and assert data_rvalid only on that owner's port; data_rdata passes to both ports unmodified.
REQ-012 SHALL treat killed transactions like others: cache still returns rvalid, which is routed and popped normally.
REQ-013 SHALL allow simultaneous push and pop in one cycle when not full; occupancy is unchanged.
REQ-014 SHALL flag an assertion error if rvalid arrives with the FIFO empty; the FIFO stays empty and no port sees rvalid.
REQ-015 SHALL, when pf_enable_i drops, finish any locked PF handshake and in-flight PF responses, but select no new PF requests.

Reset
REQ-016 SHALL, while rst_ni=0 at a clk_i edge, clear FIFO, lock, tag_owner_q and starve counter.
REQ-017 SHALL force all output data_req, data_gnt, data_rvalid, tag_valid and kill_req to 0 during and after reset until new requests arrive; data fields are 0.
REQ-018 SHALL discard in-flight transactions on reset mid-operation; later stray rvalids fall under REQ-014.

Configuration
REQ-019 SHALL, when PF_ARB_STARVE_PROTECT_EN is defined, count cycles where pf data_req=1, pf_enable_i=1 and PF is not granted; when count reaches PF_STARVE_LIMIT, PF gets priority at the next unlocked selection; counter clears on any PF grant or when pf data_req=0.
REQ-020 SHALL, when PF_ARB_STARVE_PROTECT_EN is undefined, have no counter and use strict CPU priority.

Verification
REQ-021 CPU load alone, gnt same cycle -> cache tag_valid from CPU next cycle; rvalid 2 cycles later reaches cpu_port_o only, rdata 0xDEADBEEF_00000001.
REQ-022 CPU and PF req together every cycle, macro undefined -> 100 cycles, PF never granted.
REQ-023 Same stimulus, macro defined, PF_STARVE_LIMIT=4 -> PF granted after 4 blocked cycles, then CPU resumes.
REQ-024 MAX_OUTSTANDING=2, two grants without rvalid -> third data_req held 0; after one rvalid, next cycle forwards it.
REQ-025 PF granted, CPU granted next cycle, in-order rvalids -> first to pf_port_o, second to cpu_port_o; tag phases from PF then CPU.
REQ-026 rst_ni=0 with 2 outstanding -> FIFO empty, all outputs 0; stray rvalid -> assertion error, no port rvalid.
